// File: rtl/relogio_contador.sv
// 24-hour HH:MM:SS timekeeping core: divides clk_100MHz to a 1 Hz tick, with
// pause hold and a single-cycle load from the adjust controller.
module relogio_contador #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       pause,
  input  logic       load,
  input  logic [5:0] segundos_load,
  input  logic [5:0] minutos_load,
  input  logic [5:0] horas_load,
  output logic [5:0] segundos,
  output logic [5:0] minutos,
  output logic [5:0] horas,
  output logic       tick_1hz,
  output logic       virada_dia
);

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [5:0]       seg_q, seg_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       hr_q, hr_d;
  logic             tick_q, tick_d;
  logic             vir_q, vir_d;

  always_comb begin
    presc_d = presc_q;
    seg_d   = seg_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;
    vir_d   = 1'b0;
    if (load) begin
      // Out-of-range fields are forced to zero independently of each other.
      presc_d = '0;
      seg_d   = (segundos_load > 6'd59) ? 6'd0 : segundos_load;
      min_d   = (minutos_load > 6'd59) ? 6'd0 : minutos_load;
      hr_d    = (horas_load > 6'd23) ? 6'd0 : horas_load;
    end else if (!pause) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (seg_q < 6'd59) begin
          seg_d = seg_q + 6'd1;
        end else begin
          seg_d = 6'd0;
          if (min_q < 6'd59) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d = 6'd0;
            if (hr_q < 6'd23) begin
              hr_d = hr_q + 6'd1;
            end else begin
              hr_d  = 6'd0;
              vir_d = 1'b1;
            end
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      presc_q <= '0;
      seg_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 6'd0;
      tick_q  <= 1'b0;
      vir_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      vir_q   <= vir_d;
    end
  end

  assign segundos   = seg_q;
  assign minutos    = min_q;
  assign horas      = hr_q;
  assign tick_1hz   = tick_q;
  assign virada_dia = vir_q;

endmodule

// File: tb/tb_relogio_contador.sv
// Self-checking bench for relogio_contador: directed scenarios plus random
// pause/load/rst traffic against a seconds-of-day reference model.
module tb_relogio_contador;

  localparam int unsigned Tps  = 4;
  localparam int unsigned CntW = 3;

  logic       clk_100MHz = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [5:0] segundos_load = '0;
  logic [5:0] minutos_load = '0;
  logic [5:0] horas_load = '0;
  logic [5:0] segundos, minutos, horas;
  logic       tick_1hz, virada_dia;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model: time as seconds since midnight plus cycles into the second.
  int m_t = 0;
  int m_cyc = 0;
  bit m_tick = 1'b0;
  bit m_vir = 1'b0;

  relogio_contador #(
    .TICKS_PER_SEC(Tps),
    .CNT_W        (CntW)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .pause        (pause),
    .load         (load),
    .segundos_load(segundos_load),
    .minutos_load (minutos_load),
    .horas_load   (horas_load),
    .segundos     (segundos),
    .minutos      (minutos),
    .horas        (horas),
    .tick_1hz     (tick_1hz),
    .virada_dia   (virada_dia)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic int lim(input int v, input int max);
    return (v > max) ? 0 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_state(input string name, input int h, input int m, input int s,
                              input int tk, input int vr);
    chk({name, ".horas"}, int'(horas), h);
    chk({name, ".minutos"}, int'(minutos), m);
    chk({name, ".segundos"}, int'(segundos), s);
    chk({name, ".tick_1hz"}, int'(tick_1hz), tk);
    chk({name, ".virada_dia"}, int'(virada_dia), vr);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic set_load(input int h, input int m, input int s);
    horas_load    = 6'(h);
    minutos_load  = 6'(m);
    segundos_load = 6'(s);
  endtask

  always @(posedge clk_100MHz) begin
    if (rst) begin
      m_t = 0; m_cyc = 0; m_tick = 0; m_vir = 0;
    end else if (load) begin
      m_t = lim(int'(horas_load), 23) * 3600 + lim(int'(minutos_load), 59) * 60 +
            lim(int'(segundos_load), 59);
      m_cyc = 0; m_tick = 0; m_vir = 0;
    end else if (pause) begin
      m_tick = 0; m_vir = 0;
    end else begin
      m_cyc++;
      m_tick = 0; m_vir = 0;
      if (m_cyc == Tps) begin
        m_cyc  = 0;
        m_t    = (m_t + 1) % 86400;
        m_tick = 1;
        m_vir  = (m_t == 0);
      end
    end
  end

  always @(negedge clk_100MHz) begin
    if (check_en) begin
      expect_state("model", m_t / 3600, (m_t / 60) % 60, m_t % 60, int'(m_tick), int'(m_vir));
    end
  end

  initial begin
    int r;
    cycles(1);
    check_en = 1'b1;
    expect_state("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    cycles(3);
    expect_state("pre_first_tick", 0, 0, 0, 0, 0);
    cycles(1);
    expect_state("first_tick", 0, 0, 1, 1, 0);
    cycles(1);
    expect_state("tick_drop", 0, 0, 1, 0, 0);
    cycles(235);
    expect_state("one_minute", 0, 1, 0, 1, 0);

    load = 1'b1;
    set_load(23, 59, 58);
    cycles(1);
    load = 1'b0;
    expect_state("load_235958", 23, 59, 58, 0, 0);
    cycles(7);
    expect_state("at_235959", 23, 59, 59, 0, 0);
    cycles(1);
    expect_state("midnight", 0, 0, 0, 1, 1);
    cycles(1);
    expect_state("midnight_after", 0, 0, 0, 0, 0);

    cycles(1);
    pause = 1'b1;
    cycles(20);
    expect_state("paused", 0, 0, 0, 0, 0);
    pause = 1'b0;
    cycles(1);
    expect_state("resume_1", 0, 0, 0, 0, 0);
    cycles(1);
    expect_state("resume_2", 0, 0, 1, 1, 0);

    cycles(3);
    load = 1'b1;
    set_load(10, 20, 30);
    cycles(1);
    load = 1'b0;
    expect_state("load_on_tick", 10, 20, 30, 0, 0);
    cycles(3);
    expect_state("after_load_3", 10, 20, 30, 0, 0);
    cycles(1);
    expect_state("after_load_4", 10, 20, 31, 1, 0);

    pause = 1'b1;
    load = 1'b1;
    set_load(25, 45, 61);
    cycles(1);
    load = 1'b0;
    expect_state("load_oor", 0, 45, 0, 0, 0);
    cycles(8);
    expect_state("load_pause_hold", 0, 45, 0, 0, 0);

    rst = 1'b1;
    load = 1'b1;
    set_load(12, 34, 56);
    cycles(1);
    expect_state("rst_beats_load", 0, 0, 0, 0, 0);
    rst = 1'b0;
    load = 1'b0;
    pause = 1'b0;
    cycles(3);
    expect_state("rst_restart_3", 0, 0, 0, 0, 0);
    cycles(1);
    expect_state("rst_restart_4", 0, 0, 1, 1, 0);

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      rst = (r < 4);
      load = ($urandom_range(0, 39) == 0);
      if (pause) pause = ($urandom_range(0, 3) != 0);
      else pause = ($urandom_range(0, 15) == 0);
      if (load) begin
        if ($urandom_range(0, 1) == 0) set_load(23, 59, int'($urandom_range(50, 59)));
        else set_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 63)));
      end
      cycles(1);
    end

    @(negedge clk_100MHz);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
